// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Refills whole lines on read misses and forwards each write to memory over a req/ack handshake.
module dm_cache_controller #(
    parameter int unsigned TAG_BITS   = 6,
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned WORD_BITS  = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [TAG_BITS-1:0]   tag,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [WORD_BITS-1:0]  word_sel,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  hit,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [15:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned Lines = 1 << INDEX_BITS;
    localparam int unsigned Words = 1 << WORD_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StRefill,
        StWrite,
        StRespond
    } state_e;

    state_e state;

    logic [Lines-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_arr  [Lines];
    logic [DATA_WIDTH-1:0] data_arr [Lines][Words];

    logic [TAG_BITS-1:0]   tag_l;
    logic [INDEX_BITS-1:0] index_l;
    logic [WORD_BITS-1:0]  word_l;
    logic                  we_l;
    logic [DATA_WIDTH-1:0] wdata_l;
    logic                  miss_f;
    logic                  hit_rec;
    logic [WORD_BITS-1:0]  refill_cnt;

    logic                  line_hit;
    logic                  refill_last;
    logic [WORD_BITS-1:0]  refill_nxt;
    logic                  data_we;
    logic [WORD_BITS-1:0]  data_word;
    logic [DATA_WIDTH-1:0] data_val;
    logic                  tag_we;

    assign busy        = (state != StIdle);
    assign line_hit    = valid[index_l] && (tag_arr[index_l] == tag_l);
    assign refill_last = (refill_cnt == {WORD_BITS{1'b1}});
    assign refill_nxt  = refill_cnt + 1'b1;

    always_comb begin
        data_we   = 1'b0;
        data_word = word_l;
        data_val  = wdata_l;
        tag_we    = 1'b0;
        if (state == StCompare && we_l && line_hit) begin
            data_we = 1'b1;
        end else if (state == StRefill && mem_req && mem_ack) begin
            data_we   = 1'b1;
            data_word = refill_cnt;
            data_val  = mem_rdata;
            tag_we    = refill_last;
        end
    end

    // Tag and data storage carry no reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_arr[index_l][data_word] <= data_val;
        end
        if (tag_we) begin
            tag_arr[index_l] <= tag_l;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            valid      <= '0;
            tag_l      <= '0;
            index_l    <= '0;
            word_l     <= '0;
            we_l       <= 1'b0;
            wdata_l    <= '0;
            miss_f     <= 1'b0;
            hit_rec    <= 1'b0;
            refill_cnt <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            hit        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (cpu_req) begin
                        tag_l   <= tag;
                        index_l <= index;
                        word_l  <= word_sel;
                        we_l    <= cpu_we;
                        wdata_l <= cpu_wdata;
                        state   <= StCompare;
                    end
                end
                StCompare: begin
                    if (we_l) begin
                        hit_rec   <= line_hit;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {tag_l, index_l, word_l, 3'b000};
                        mem_wdata <= wdata_l;
                        state     <= StWrite;
                    end else if (line_hit) begin
                        cpu_rdata <= data_arr[index_l][word_l];
                        hit       <= ~miss_f;
                        cpu_ready <= 1'b1;
                        state     <= StRespond;
                    end else begin
                        miss_f     <= 1'b1;
                        refill_cnt <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {tag_l, index_l, {WORD_BITS{1'b0}}, 3'b000};
                        state      <= StRefill;
                    end
                end
                StRefill: begin
                    if (mem_req && mem_ack) begin
                        refill_cnt <= refill_nxt;
                        if (refill_last) begin
                            mem_req        <= 1'b0;
                            valid[index_l] <= 1'b1;
                            state          <= StCompare;
                        end else begin
                            mem_addr <= {tag_l, index_l, refill_nxt, 3'b000};
                        end
                    end
                end
                StWrite: begin
                    if (mem_req && mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        hit       <= hit_rec;
                        cpu_ready <= 1'b1;
                        state     <= StRespond;
                    end
                end
                StRespond: begin
                    cpu_ready <= 1'b0;
                    miss_f    <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench for dm_cache_controller: vector table of CPU accesses against a memory model,
// plus stray-ack and reset-during-refill sequences.
module tb_dm_cache_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [5:0]  tag;
    logic [4:0]  index;
    logic [1:0]  word_sel;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        hit;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    dm_cache_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .tag       (tag),
        .index     (index),
        .word_sel  (word_sel),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: background pattern, overwritten by write-through traffic.
    logic [31:0] mem [0:8191];
    bit          init_mem  = 1'b1;
    int          ack_delay = 0;
    int          wcnt      = 0;
    bit          stray     = 1'b0;
    logic [15:0] addr_q [$];

    function automatic logic [31:0] pat(input logic [15:0] a);
        logic [10:0] hi;
        logic [7:0]  lo;
        hi  = a[15:5] ^ 11'h0A3;
        lo  = 8'hA0 + {6'b0, a[4:3]};
        pat = {13'b0, hi, lo};
    endfunction

    always @(negedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 8192; k++) begin
                mem[k] <= pat({k[12:0], 3'b000});
            end
            init_mem <= 1'b0;
        end else if (mem_req && rst_n) begin
            if (wcnt >= ack_delay) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem[mem_addr[15:3]];
                wcnt      <= 0;
                addr_q.push_back(mem_addr);
                if (mem_we) mem[mem_addr[15:3]] <= mem_wdata;
            end else begin
                mem_ack <= 1'b0;
                wcnt    <= wcnt + 1;
            end
        end else begin
            mem_ack <= stray;
            wcnt    <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issues one access and returns the cycle count from the sampling edge to cpu_ready.
    task automatic txn(input logic we, input logic [5:0] t, input logic [4:0] i,
                       input logic [1:0] w, input logic [31:0] d,
                       output logic [31:0] rd, output logic h, output int lat);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        tag       = t;
        index     = i;
        word_sel  = w;
        cpu_wdata = d;
        @(negedge clk);
        cpu_req = 1'b0;
        lat     = 1;
        chk("busy_in_compare", {31'b0, busy}, 32'd1);
        while (!cpu_ready && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        rd = cpu_rdata;
        h  = hit;
        if (!cpu_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  tag;
        logic [4:0]  idx;
        logic [1:0]  word;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        hit;
        int          lat;
        logic [15:0] addr0;
        int          beats;
        int          delay;
    } vec_t;

    vec_t vecs [11];

    task automatic check_beats(input string nm, input logic [15:0] a0, input int beats);
        chk({nm, "_beats"}, addr_q.size(), beats);
        for (int b = 0; b < beats && b < addr_q.size(); b++) begin
            chk({nm, "_addr"}, {16'b0, addr_q[b]}, {16'b0, a0 + 16'(8 * b)});
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        h;
        int          lat;
        int          guard;

        vecs[0]  = '{1'b0, 6'h05, 5'd3,  2'd2, 32'h0,        32'h000000A2, 1'b0, 7,  16'h1460, 4, 0};
        vecs[1]  = '{1'b0, 6'h05, 5'd3,  2'd1, 32'h0,        32'h000000A1, 1'b1, 2,  16'h0000, 0, 0};
        vecs[2]  = '{1'b1, 6'h05, 5'd3,  2'd1, 32'hDEADBEEF, 32'h0,        1'b1, 3,  16'h1468, 1, 0};
        vecs[3]  = '{1'b0, 6'h05, 5'd3,  2'd1, 32'h0,        32'hDEADBEEF, 1'b1, 2,  16'h0000, 0, 0};
        vecs[4]  = '{1'b0, 6'h06, 5'd3,  2'd0, 32'h0,        32'h000060A0, 1'b0, 7,  16'h1860, 4, 0};
        vecs[5]  = '{1'b0, 6'h05, 5'd3,  2'd1, 32'h0,        32'hDEADBEEF, 1'b0, 7,  16'h1460, 4, 0};
        vecs[6]  = '{1'b1, 6'h3F, 5'd31, 2'd3, 32'h12345678, 32'h0,        1'b0, 3,  16'hFFF8, 1, 0};
        vecs[7]  = '{1'b0, 6'h3F, 5'd31, 2'd3, 32'h0,        32'h12345678, 1'b0, 7,  16'hFFE0, 4, 0};
        vecs[8]  = '{1'b0, 6'h3F, 5'd31, 2'd0, 32'h0,        32'h00075CA0, 1'b1, 2,  16'h0000, 0, 0};
        vecs[9]  = '{1'b1, 6'h01, 5'd0,  2'd0, 32'hCAFEF00D, 32'h0,        1'b0, 5,  16'h0400, 1, 2};
        vecs[10] = '{1'b0, 6'h01, 5'd0,  2'd0, 32'h0,        32'hCAFEF00D, 1'b0, 11, 16'h0400, 4, 1};

        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        tag       = '0;
        index     = '0;
        word_sel  = '0;
        cpu_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_hit", {31'b0, hit}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // Acks with no request outstanding must not start anything.
        stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_busy", {31'b0, busy}, 32'd0);
        chk("stray_mem_req", {31'b0, mem_req}, 32'd0);
        stray = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            ack_delay = vecs[v].delay;
            addr_q.delete();
            txn(vecs[v].we, vecs[v].tag, vecs[v].idx, vecs[v].word, vecs[v].wdata, rd, h, lat);
            chk($sformatf("v%0d_lat", v), lat, vecs[v].lat);
            chk($sformatf("v%0d_hit", v), {31'b0, h}, {31'b0, vecs[v].hit});
            if (!vecs[v].we) chk($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
            check_beats($sformatf("v%0d", v), vecs[v].addr0, vecs[v].beats);
        end

        // Reset during a refill: request drops at once and the line stays invalid.
        ack_delay = 0;
        addr_q.delete();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        tag      = 6'h02;
        index    = 5'd5;
        word_sel = 2'd0;
        @(negedge clk);
        cpu_req = 1'b0;
        guard   = 0;
        while (addr_q.size() < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_two_acks", addr_q.size(), 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        addr_q.delete();
        txn(1'b0, 6'h02, 5'd5, 2'd1, 32'h0, rd, h, lat);
        chk("postrst_lat", lat, 7);
        chk("postrst_hit", {31'b0, h}, 32'd0);
        chk("postrst_rdata", rd, 32'h0000E6A1);
        check_beats("postrst", 16'h08A0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
